// File: rtl/cache_fill_ctrl.sv
// Line-fill engine: on a miss it pulls one full cache line from memory over valid/ready
// and writes it word by word into cache_block through its index/we/din write port.
module cache_fill_ctrl #(
    parameter int unsigned NUM_OF_ENTRY = 1024,
    parameter int unsigned ENTRY_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OFFSET_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fill_req,
    input  logic [ENTRY_WIDTH-1:0]  fill_index,
    output logic                    fill_busy,
    output logic                    fill_done,
    input  logic                    mem_valid,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    mem_ready,
    output logic [ENTRY_WIDTH-1:0]  index,
    output logic                    we,
    output logic [DATA_WIDTH-1:0]   din
);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    localparam logic [ENTRY_WIDTH-1:0]  OFFSET_MASK = ENTRY_WIDTH'((1 << OFFSET_WIDTH) - 1);
    localparam logic [ENTRY_WIDTH-1:0]  ENTRY_MASK  = ENTRY_WIDTH'(NUM_OF_ENTRY - 1);
    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD   = '1;

    state_e                  state;
    logic [ENTRY_WIDTH-1:0]  base;
    logic [OFFSET_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= StIdle;
            base  <= '0;
            cnt   <= '0;
            index <= '0;
            we    <= 1'b0;
            din   <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                StIdle: begin
                    if (fill_req) begin
                        base  <= fill_index & ~OFFSET_MASK;
                        cnt   <= '0;
                        state <= StFill;
                    end
                end
                StFill: begin
                    if (mem_valid) begin
                        we    <= 1'b1;
                        // OR, not add: the word offset only fills the cleared low bits
                        index <= (base | ENTRY_WIDTH'(cnt)) & ENTRY_MASK;
                        din   <= mem_data;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_WORD) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign mem_ready = (state == StFill);
    assign fill_busy = (state != StIdle);
    assign fill_done = (state == StDone);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl; a small array stands in for cache_block and
// records every write the engine issues.
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fill_req;
    logic [9:0]  fill_index;
    logic        fill_busy;
    logic        fill_done;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [9:0]  index;
    logic        we;
    logic [31:0] din;

    int checks = 0;
    int errors = 0;
    int nwrites = 0;
    bit saw_zero = 0;
    logic [31:0] mem [1024];

    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    cache_fill_ctrl #(
        .NUM_OF_ENTRY (1024),
        .ENTRY_WIDTH  (10),
        .DATA_WIDTH   (32),
        .OFFSET_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_req   (fill_req),
        .fill_index (fill_index),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .index      (index),
        .we         (we),
        .din        (din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample just after the edge; record the write landing now.
    task automatic tick();
        @(posedge clk);
        #1;
        if (we === 1'b1) begin
            mem[index] = din;
            nwrites++;
            if (index == 10'h000) saw_zero = 1;
        end
    endtask

    task automatic chk_out(input string tag, input logic busy, input logic done,
                           input logic rdy, input logic w, input logic [9:0] idx,
                           input logic [31:0] d);
        chk({tag, "_busy"}, {31'b0, fill_busy}, {31'b0, busy});
        chk({tag, "_done"}, {31'b0, fill_done}, {31'b0, done});
        chk({tag, "_ready"}, {31'b0, mem_ready}, {31'b0, rdy});
        chk({tag, "_we"}, {31'b0, we}, {31'b0, w});
        chk({tag, "_index"}, {22'b0, index}, {22'b0, idx});
        chk({tag, "_din"}, din, d);
    endtask

    // Request at cycle T, then one word per cycle; 'gap' idle cycles before word 2.
    task automatic run_fill(input string tag, input logic [9:0] idx, input logic [9:0] eb,
                            input logic [31:0] d, input int gap,
                            input logic req_after, input logic [9:0] idx_after);
        nwrites    = 0;
        fill_req   = 1'b1;
        fill_index = idx;
        mem_valid  = 1'b1;       // ignored while in idle
        mem_data   = 32'h5555_5555;
        tick();
        fill_req   = req_after;
        fill_index = idx_after;
        chk({tag, "_start_busy"}, {31'b0, fill_busy}, 32'd1);
        chk({tag, "_start_ready"}, {31'b0, mem_ready}, 32'd1);
        chk({tag, "_start_we"}, {31'b0, we}, 32'd0);
        for (int w = 0; w < 4; w++) begin
            if (w == 2) begin
                for (int g = 0; g < gap; g++) begin
                    mem_valid = 1'b0;
                    mem_data  = 32'hFFFF_FFFF;
                    tick();
                    chk_out({tag, "_gap"}, 1'b1, 1'b0, 1'b1, 1'b0, eb | 10'd1, d + 32'd1);
                end
            end
            mem_valid = 1'b1;
            mem_data  = d + 32'(w);
            tick();
            chk_out({tag, "_wr"}, 1'b1, (w == 3), (w != 3), 1'b1, eb | 10'(w), d + 32'(w));
        end
        mem_valid = 1'b0;
        tick();
        chk_out({tag, "_end"}, 1'b0, 1'b0, 1'b0, 1'b0, eb | 10'd3, d + 32'd3);
        chk({tag, "_nwrites"}, 32'(nwrites), 32'd4);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = SENT;
        rst_n      = 1'b0;
        fill_req   = 1'b1;
        fill_index = 10'h006;
        mem_valid  = 1'b1;
        mem_data   = 32'h1234_5678;

        // Reset held for two cycles with a pending request.
        tick();
        tick();
        chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
        rst_n     = 1'b1;
        fill_req  = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk_out("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0);

        // Basic back-to-back fill of line 0x004.
        run_fill("basic", 10'h006, 10'h004, 32'h0000_00A0, 0, 1'b0, 10'h3FF);
        chk("basic_m4", mem[10'h004], 32'hA0);
        chk("basic_m5", mem[10'h005], 32'hA1);
        chk("basic_rd6", mem[10'h006], 32'hA2);
        chk("basic_m7", mem[10'h007], 32'hA3);

        // Three idle cycles between words 1 and 2.
        run_fill("stall", 10'h010, 10'h010, 32'h0000_00B0, 3, 1'b0, 10'h000);
        chk("stall_m10", mem[10'h010], 32'hB0);
        chk("stall_m13", mem[10'h013], 32'hB3);

        // Top line must not wrap.
        saw_zero = 0;
        run_fill("top", 10'h3FF, 10'h3FC, 32'h0000_00C0, 0, 1'b0, 10'h001);
        chk("top_m3fc", mem[10'h3FC], 32'hC0);
        chk("top_m3ff", mem[10'h3FF], 32'hC3);
        chk("top_nozero", {31'b0, saw_zero}, 32'd0);
        chk("top_m000", mem[10'h000], SENT);

        // Request for 0x020 held through the fill of 0x040: ignored, then taken at T+6.
        run_fill("ign", 10'h041, 10'h040, 32'h0000_00D0, 0, 1'b1, 10'h020);
        chk("ign_m40", mem[10'h040], 32'hD0);
        chk("ign_m43", mem[10'h043], 32'hD3);
        chk("ign_m20", mem[10'h020], SENT);
        run_fill("ign2", 10'h020, 10'h020, 32'h0000_00E0, 0, 1'b0, 10'h000);
        chk("ign2_m20", mem[10'h020], 32'hE0);
        chk("ign2_m23", mem[10'h023], 32'hE3);

        // Reset after two words of line 0x080.
        fill_req   = 1'b1;
        fill_index = 10'h080;
        tick();
        fill_req   = 1'b0;
        mem_valid  = 1'b1;
        mem_data   = 32'hF0;
        tick();
        chk_out("mid_w0", 1'b1, 1'b0, 1'b1, 1'b1, 10'h080, 32'hF0);
        mem_data = 32'hF1;
        tick();
        chk_out("mid_w1", 1'b1, 1'b0, 1'b1, 1'b1, 10'h081, 32'hF1);
        rst_n    = 1'b0;
        mem_data = 32'hF2;
        tick();
        chk_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
        rst_n = 1'b1;
        tick();
        chk_out("mid_after", 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
        mem_valid = 1'b0;
        tick();
        chk("mid_m80", mem[10'h080], 32'hF0);
        chk("mid_m81", mem[10'h081], 32'hF1);
        chk("mid_m82", mem[10'h082], SENT);
        chk("mid_m83", mem[10'h083], SENT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Line-fill engine that writes a whole cache line into `cache_block` after a miss. It accepts one fill request carrying a line base index and takes `2^OFFSET_WIDTH` words from the memory side over a valid/ready handshake. It drives `cache_block`'s `index`/`we`/`din` write port, one word per cycle, and pulses `fill_done` when the line is complete. It is the writer for the read port exercised by `cache_block`.

## Interface
- `NUM_OF_ENTRY`, `_1K`: number of word entries in `cache_block`.
- `ENTRY_WIDTH`, 10: width of the entry index; `2^ENTRY_WIDTH == NUM_OF_ENTRY`.
- `DATA_WIDTH`, `_4B` (32): word width.
- `OFFSET_WIDTH`, 2: words per line = `2^OFFSET_WIDTH` (4).

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `fill_req` in 1: fill request; sampled only in IDLE.
- `fill_index` in ENTRY_WIDTH: any entry in the target line; the low OFFSET_WIDTH bits are ignored.
- `fill_busy` out 1: high in every state except IDLE.
- `fill_done` out 1: one-cycle pulse when the line is fully written.
- `mem_valid` in 1: memory word valid.
- `mem_data` in DATA_WIDTH: memory word.
- `mem_ready` out 1: engine can accept a word.
- `index` out ENTRY_WIDTH: `cache_block` entry index.
- `we` out 1: `cache_block` write enable.
- `din` out DATA_WIDTH: `cache_block` write data.

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - If `fill_req`=1: latch `base = {fill_index[ENTRY_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'b0}`, clear word counter `cnt`, go to FILL.
  - If `fill_req`=0: stay in IDLE.
- FILL:
  - `mem_ready`=1.
  - A word is accepted in any cycle with `mem_valid && mem_ready`.
  - On accept, next cycle drives `we`=1, `index = base | cnt`, `din` = accepted `mem_data`, and `cnt` increments.
  - No accept: next-cycle `we`=0; `index`/`din` hold their last value.
  - Accepting word `2^OFFSET_WIDTH - 1` moves to DONE.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - `mem_ready`=0 and `fill_done`=1; the last word's `we`=1 falls in this cycle.
- Word order is ascending offset 0..N-1.
- Index arithmetic: `base | cnt`, never an add. The line never crosses a line boundary; top line `0x3FC`–`0x3FF` does not wrap to 0.
- `cnt` is OFFSET_WIDTH bits wide; its wrap from N-1 to 0 coincides with leaving FILL.
- `fill_req` in FILL/DONE is ignored and not queued; `fill_index` changes after the IDLE sample have no effect.
- `mem_valid` while `mem_ready`=0 is ignored; no data is consumed.
- `mem_valid` gaps in FILL stall the fill indefinitely; there is no timeout.

## Timing
- Reset (`rst_n`=0 at an edge) → state IDLE, `cnt`=0, `base`=0, `index`=0, `we`=0, `din`=0, `fill_busy`=0, `fill_done`=0, `mem_ready`=0.
- Reset mid-fill: the fill is abandoned. `we` is 0 from the first cycle after the reset edge, so no further writes occur. Words already written stay in `cache_block`.
- `mem_ready`, `fill_busy` and `fill_done` are decoded from the registered state.
- `index`, `we` and `din` are registered: each write lands one cycle after its accept.
- Back-to-back case: `fill_req` at cycle T.
  - T+1..T+4: FILL, words accepted.
  - T+2..T+5: writes.
  - T+5: DONE; `fill_done`=1.
  - T+6: IDLE, `fill_busy`=0; a new `fill_req` is sampled at T+6 at the earliest.
- Minimum fill: `2^OFFSET_WIDTH + 2` cycles from request to IDLE.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles while `fill_req`=1 → all outputs 0; after release, the fill starts on the next `fill_req`.
- Basic fill: `fill_index`=`0x006`, `mem_data` = `0xA0`,`0xA1`,`0xA2`,`0xA3` back-to-back:
  - writes `0x004`←`0xA0`, `0x005`←`0xA1`, `0x006`←`0xA2`, `0x007`←`0xA3` on T+2..T+5;
  - `fill_done` high only at T+5;
  - a `cache_block` read of `0x006` then returns `0xA2`.
- Stall: `fill_index`=`0x010`, `mem_valid` low for 3 cycles between words 1 and 2 → `we`=0 during the gap, `index`/`din` hold; writes `0x010`–`0x013` are correct; `fill_done` is 3 cycles later than the back-to-back case.
- Top line: `fill_index`=`0x3FF` → writes `0x3FC`–`0x3FF`; `index` never equals `0x000`.
- Ignored request: second `fill_req` (`fill_index`=`0x020`) during FILL of line `0x040` → only `0x040`–`0x043` written. A `fill_req` held into T+6 starts a new fill at `0x020`.
- Mid-fill reset: assert `rst_n`=0 after 2 words of line `0x080` → `0x080` and `0x081` written; `we`=0 from the cycle after reset; `0x082`/`0x083` untouched; `mem_ready`=0.
